// File: rtl/ca_scroll_engine.sv
`default_nettype none
// ============================================================================
// Module   : ca_scroll_engine
// Brief    : 1-D elementary cellular automaton feeding a scrolling frame-buffer
//            ring. Define CA_WRAP_EN for a toroidal row (default: zero edges).
// Revision : 1.0 - initial release
// ============================================================================
module ca_scroll_engine #(
    parameter int CELLS  = 100,
    parameter int ROWS   = 100,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    input  logic [7:0]        rule,
    input  logic              wr_ok,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CELLS-1:0]  wr_data,
    output logic              init_rdy,
    output logic              busy,
    output logic [ADDR_W-1:0] top_row,
    output logic [15:0]       gen_count,
    output logic              ovf
);

    typedef enum logic [2:0] {
        S_CLEAR   = 3'd0,
        S_SEED    = 3'd1,
        S_IDLE    = 3'd2,
        S_COMPUTE = 3'd3,
        S_WRITE   = 3'd4
    } state_t;

    localparam logic [CELLS-1:0]  SEED_ROW = CELLS'(1) << (CELLS / 2);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] HEAD_INI = ADDR_W'((ROWS > 1) ? 1 : 0);

    state_t             state;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [ADDR_W-1:0]  head;
    logic [ADDR_W-1:0]  head_inc;
    logic [CELLS-1:0]   row;
    logic [CELLS-1:0]   nxt;
    logic [CELLS-1:0]   nxt_c;
    logic [CELLS+1:0]   ext;
    logic               pending;

    // ext[i], ext[i+1], ext[i+2] are the L, C, R neighbours of cell i
    always_comb begin
`ifdef CA_WRAP_EN
        ext = {row[0], row, row[CELLS-1]};
`else
        ext = {1'b0, row, 1'b0};
`endif
        nxt_c = '0;
        for (int i = 0; i < CELLS; i++) begin
            nxt_c[i] = rule[{ext[i], ext[i+1], ext[i+2]}];
        end
    end

    assign head_inc = (head == LAST_ROW) ? '0 : head + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_CLEAR;
            clr_cnt   <= '0;
            head      <= '0;
            gen_count <= '0;
            pending   <= 1'b0;
            ovf       <= 1'b0;
            init_rdy  <= 1'b0;
            row       <= '0;
            nxt       <= '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ROW) state <= S_SEED;
                end
                S_SEED: begin
                    row      <= SEED_ROW;
                    head     <= HEAD_INI;
                    init_rdy <= 1'b1;
                    state    <= S_IDLE;
                end
                S_IDLE: begin
                    if (step) state <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    nxt   <= nxt_c;
                    state <= S_WRITE;
                    if (step) begin
                        if (pending) ovf <= 1'b1;
                        else         pending <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (wr_ok) begin
                        row       <= nxt;
                        head      <= head_inc;
                        gen_count <= gen_count + 16'd1;
                        // a step on the completion cycle is consumed as the pending request
                        if (pending) begin
                            pending <= 1'b0;
                            state   <= S_COMPUTE;
                            if (step) ovf <= 1'b1;
                        end else if (step) begin
                            state <= S_COMPUTE;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (step) begin
                        if (pending) ovf <= 1'b1;
                        else         pending <= 1'b1;
                    end
                end
                default: state <= S_CLEAR;
            endcase
        end
    end

    assign wr_en = !rst && ((state == S_CLEAR) || (state == S_SEED) ||
                            ((state == S_WRITE) && wr_ok));
    assign busy    = !rst && (state != S_IDLE);
    assign top_row = head;

    always_comb begin
        wr_addr = '0;
        wr_data = '0;
        if (!rst) begin
            case (state)
                S_CLEAR: wr_addr = clr_cnt;
                S_SEED:  wr_data = SEED_ROW;
                S_WRITE: begin
                    wr_addr = head;
                    wr_data = nxt;
                end
                default: wr_addr = head;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ca_scroll_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_scroll_engine
// Brief    : Self-checking bench for ca_scroll_engine against a row-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca_scroll_engine;

    localparam int CELLS  = 100;
    localparam int ROWS   = 100;
    localparam int ADDR_W = 7;
`ifdef CA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              step;
    logic [7:0]        rule;
    logic              wr_ok;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [CELLS-1:0]  wr_data;
    logic              init_rdy;
    logic              busy;
    logic [ADDR_W-1:0] top_row;
    logic [15:0]       gen_count;
    logic              ovf;

    ca_scroll_engine #(.CELLS(CELLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .step(step), .rule(rule), .wr_ok(wr_ok),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .init_rdy(init_rdy), .busy(busy), .top_row(top_row),
        .gen_count(gen_count), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [CELLS-1:0] m_row;
    int               m_head;
    int               m_gen;
    logic             m_ovf;
    logic [CELLS-1:0] last_data;
    logic [CELLS-1:0] seed_row;

    function automatic logic [CELLS-1:0] model_next(input logic [CELLS-1:0] cur, input int r);
        logic [CELLS-1:0] res;
        int l, c, rt, k;
        res = '0;
        for (int i = 0; i < CELLS; i++) begin
            c  = int'(cur[i]);
            l  = (i == 0 && !WRAP) ? 0 : int'(cur[(i + CELLS - 1) % CELLS]);
            rt = (i == CELLS - 1 && !WRAP) ? 0 : int'(cur[(i + 1) % CELLS]);
            k  = 4 * l + 2 * c + rt;
            res[i] = ((r / (1 << k)) % 2) == 1;
        end
        return res;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_and_init;
        rst   = 1'b1;
        step  = 1'b0;
        wr_ok = 1'b0;
        repeat (3) tick;
        check("rst_wr_en",   128'(wr_en), 128'(0));
        check("rst_busy",    128'(busy), 128'(0));
        check("rst_wr_data", 128'(wr_data), 128'(0));
        check("rst_wr_addr", 128'(wr_addr), 128'(0));
        check("rst_init",    128'(init_rdy), 128'(0));
        check("rst_top_row", 128'(top_row), 128'(0));
        check("rst_gen",     128'(gen_count), 128'(0));
        check("rst_ovf",     128'(ovf), 128'(0));
        rst = 1'b0;
        #1;
        for (int k = 0; k < ROWS; k++) begin
            step = 1'($urandom_range(0, 1));
            check("clr_wr_en", 128'(wr_en), 128'(1));
            check("clr_addr",  128'(wr_addr), 128'(k));
            check("clr_data",  128'(wr_data), 128'(0));
            check("clr_busy",  128'(busy), 128'(1));
            tick;
        end
        step = 1'($urandom_range(0, 1));
        check("seed_wr_en", 128'(wr_en), 128'(1));
        check("seed_addr",  128'(wr_addr), 128'(0));
        check("seed_data",  128'(wr_data), 128'(seed_row));
        tick;
        step = 1'b0;
        check("init_rdy",     128'(init_rdy), 128'(1));
        check("init_busy",    128'(busy), 128'(0));
        check("init_top_row", 128'(top_row), 128'(1));
        check("init_wr_en",   128'(wr_en), 128'(0));
        m_row  = seed_row;
        m_head = 1;
        m_gen  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic do_gen(input int r, input int hold);
        logic [CELLS-1:0] exp;
        rule  = 8'(r);
        step  = 1'b1;
        wr_ok = 1'($urandom_range(0, 1));
        tick;
        step = 1'b0;
        check("compute_wr_en", 128'(wr_en), 128'(0));
        check("compute_busy",  128'(busy), 128'(1));
        exp   = model_next(m_row, r);
        wr_ok = (hold == 0);
        tick;
        for (int h = 0; h < hold; h++) begin
            check("hold_wr_en", 128'(wr_en), 128'(0));
            check("hold_busy",  128'(busy), 128'(1));
            tick;
        end
        wr_ok = 1'b1;
        #1;
        check("write_wr_en", 128'(wr_en), 128'(1));
        check("write_addr",  128'(wr_addr), 128'(m_head));
        check("write_data",  128'(wr_data), 128'(exp));
        last_data = wr_data;
        tick;
        m_row  = exp;
        m_head = (m_head + 1) % ROWS;
        m_gen  = (m_gen + 1) % 65536;
        check("idle_wr_en",   128'(wr_en), 128'(0));
        check("idle_busy",    128'(busy), 128'(0));
        check("idle_top_row", 128'(top_row), 128'(m_head));
        check("idle_gen",     128'(gen_count), 128'(m_gen));
        check("idle_ovf",     128'(ovf), 128'(m_ovf));
    endtask

    initial begin
        logic [CELLS-1:0] n1, n2;
        seed_row = '0;
        seed_row[CELLS/2] = 1'b1;
        rule = 8'd0;
        last_data = '0;

        reset_and_init;

        do_gen(90, 0);
        do_gen(30, 20);

        // fill the ring up to the last row, then confirm the wrap to row 0
        repeat (97) do_gen(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        check("ring_top_row_wrap", 128'(top_row), 128'(0));
        do_gen(int'($urandom_range(0, 255)), 0);

        // reset while a write is stalled
        rule  = 8'd30;
        step  = 1'b1;
        wr_ok = 1'b0;
        tick;
        step = 1'b0;
        tick;
        tick;
        check("midwrite_busy", 128'(busy), 128'(1));
        reset_and_init;

        // shift the seed to the right edge, then across it
        repeat (49) do_gen(240, 0);
        check("edge_pre_data", 128'(last_data), 128'(100'(1) << 99));
        do_gen(240, 0);
        check("edge_data", 128'(last_data), WRAP ? 128'(1) : 128'(0));

        // three back-to-back steps: one pending, one dropped
        n1    = model_next(m_row, 110);
        n2    = model_next(n1, 110);
        rule  = 8'd110;
        step  = 1'b1;
        wr_ok = 1'b0;
        tick;
        tick;
        wr_ok = 1'b1;
        #1;
        check("ovf_w1_en",   128'(wr_en), 128'(1));
        check("ovf_w1_addr", 128'(wr_addr), 128'(m_head));
        check("ovf_w1_data", 128'(wr_data), 128'(n1));
        tick;
        step = 1'b0;
        m_ovf = 1'b1;
        check("ovf_set",        128'(ovf), 128'(1));
        check("ovf_compute_en", 128'(wr_en), 128'(0));
        check("ovf_busy",       128'(busy), 128'(1));
        tick;
        check("ovf_w2_en",   128'(wr_en), 128'(1));
        check("ovf_w2_addr", 128'(wr_addr), 128'((m_head + 1) % ROWS));
        check("ovf_w2_data", 128'(wr_data), 128'(n2));
        tick;
        m_row  = n2;
        m_head = (m_head + 2) % ROWS;
        m_gen  = m_gen + 2;
        check("ovf_idle_busy", 128'(busy), 128'(0));
        check("ovf_idle_gen",  128'(gen_count), 128'(m_gen));
        check("ovf_idle_top",  128'(top_row), 128'(m_head));
        check("ovf_idle_en",   128'(wr_en), 128'(0));
        do_gen(int'($urandom_range(0, 255)), 1);
        check("ovf_sticky", 128'(ovf), 128'(1));

        reset_and_init;
        repeat (6) do_gen(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
